// File: rtl/vdp_cpu_pkg.sv
// Shared types for the VDP CPU port: detector FSM states and the access queue entry.
package vdp_cpu_pkg;

    localparam int VDP_ADDR_W = 2;
    localparam int VDP_DATA_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } vdp_state_t;

    // Field widths follow the default port widths of vdp_cpu_port.
    typedef struct packed {
        logic                  wrt;
        logic [VDP_ADDR_W-1:0] adr;
        logic [VDP_DATA_W-1:0] dat;
    } vdp_entry_t;

endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchroniser followed by an agreement filter: the output follows the
// synchronised pin only after FILTER_LEN consecutive samples that differ from it.
module pin_sync_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic filt_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FILTER_LEN - 1);

    logic             s1_q, s2_q, filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Everything presets to the inactive level so a pin low at release pays full latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= CNT_RELOAD;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            if (s2_q == filt_q) begin
                cnt_q <= CNT_RELOAD;
            end else if (cnt_q == '0) begin
                filt_q <= s2_q;
                cnt_q  <= CNT_RELOAD;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: filters async strobes, queues one access per strobe,
// and issues the queue head to the core with a req/ack handshake.
//   state   | meaning
//   ST_IDLE | waiting for exactly one filtered strobe to go low
//   ST_HELD | access captured; waiting for the strobe pair to change
module vdp_cpu_port
    import vdp_cpu_pkg::*;
#(
    parameter int ADDR_W     = VDP_ADDR_W,
    parameter int DATA_W     = VDP_DATA_W,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        csr_n,
    input  logic                        csw_n,
    input  logic [ADDR_W-1:0]           mode,
    input  logic [DATA_W-1:0]           cd_in,
    output logic                        req,
    output logic                        wrt,
    output logic [ADDR_W-1:0]           adr,
    output logic [DATA_W-1:0]           dbo,
    input  logic                        ack,
    input  logic [DATA_W-1:0]           dbi,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic              csr_f, csw_f;
    logic [ADDR_W-1:0] mode_f;

    pin_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_csr (
        .clk(clk), .reset(reset), .pin_i(csr_n), .filt_o(csr_f));
    pin_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_csw (
        .clk(clk), .reset(reset), .pin_i(csw_n), .filt_o(csw_f));

    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_mode
        pin_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_mode (
            .clk(clk), .reset(reset), .pin_i(mode[gi]), .filt_o(mode_f[gi]));
    end

    vdp_state_t state_q, state_d;
    logic [1:0] cap_q, cap_d;
    logic       push;
    vdp_entry_t push_ent;

    assign push_ent = {~csw_f, mode_f, cd_in};

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Both strobes low together is ambiguous and ignored.
                if (csr_f ^ csw_f) begin
                    push    = 1'b1;
                    cap_d   = {csr_f, csw_f};
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if ({csr_f, csw_f} != cap_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vdp_entry_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, pop, push_ok, drop;
    vdp_entry_t       ent_q, ent_d;
    logic             req_q, req_d;
    logic [DATA_W-1:0] rd_data_q;
    logic             rd_valid_q, overflow_q;

    assign full    = (level_q == LVL_FULL);
    assign pop     = req_q & ack;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push_ok) level_d = level_q - LVL_W'(1);
    end

    // The presented entry is refilled in the ack cycle so consecutive entries issue without a gap.
    always_comb begin
        req_d = req_q;
        ent_d = ent_q;
        if (!req_q) begin
            if (level_q != '0) begin
                req_d = 1'b1;
                ent_d = mem_q[rd_ptr_q];
            end
        end else if (ack) begin
            if (level_q > LVL_W'(1))  ent_d = mem_q[rd_ptr_q + PTR_W'(1)];
            else if (push_ok)         ent_d = push_ent;
            else                      req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cap_q      <= 2'b11;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            req_q      <= 1'b0;
            ent_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            level_q    <= level_d;
            req_q      <= req_d;
            ent_q      <= ent_d;
            rd_valid_q <= pop & ~ent_q.wrt;
            overflow_q <= overflow_q | drop;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (pop && !ent_q.wrt) rd_data_q <= dbi;
        end
    end

    assign req      = req_q;
    assign wrt      = ent_q.wrt;
    assign adr      = ent_q.adr;
    assign dbo      = ent_q.dat;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule
